spi_tx_datapath: RTL and testbench
==================================

// Module: spi_tx_datapath
// PURPOSE
//   Transmit-side datapath of the SPI master; the sequencing FSM sits above it.
//   - Contains a programmable clock divider that produces the SPI bit-rate clock.
//   - Contains a registered chip-select demux that drives one active-low CS line.
//   - Contains a parallel-in/serial-out shift register that drives MOSI.
//   - Everything runs synchronously in the clk_in domain; the divider makes a one-cycle shift tick.
// PARAMETERS
//   SIZE      40  frame width in bits (PISO length)
//   CS_SIZE   4   number of chip-select outputs
//   CLK_SIZE  3   width of divider counter / clk_count_max
// PORTS
//   clk_in         in   1                   system clock, all logic on posedge
//   reset_n_in     in   1                   asynchronous, active-low reset
//   clk_count_max  in   CLK_SIZE            divider terminal count
//   div_clk_out    out  1                   divided clock, 50% duty
//   shift_tick_out out  1                   1-cycle pulse, cycle before div_clk_out rises
//   cs_select_in   in   $clog2(CS_SIZE)     index of CS line to drive
//   cs_sig_in      in   1                   CS level (active low) for selected line
//   cs_out_n       out  CS_SIZE             registered chip-select lines
//   data_in        in   SIZE                parallel frame to load
//   load_in        in   1                   load request (sampled on tick)
//   shift_en_in    in   1                   shift request (sampled on tick)
//   serial_out     out  1                   MOSI bit
//   empty_out      out  1                   all SIZE bits shifted since last load
// BEHAVIOUR
//   Reset (async, reset_n_in=0):
//     div counter=0, div_clk_out=0, shift_tick_out=0, cs_out_n=all 1s (2**CS_SIZE-1).
//     Shift reg=0, serial_out=0, bit count=0, empty_out=1.
//   Divider (CLK_SIZE-bit counter cnt):
//     - On each clk_in edge: if cnt>=clk_count_max then cnt<=0 and div_clk_out toggles; else cnt<=cnt+1.
//     - Period is 2*(clk_count_max+1) clk_in cycles; max=0 gives clk_in/2.
//     - The compare is >=, so lowering max mid-count wraps on the next edge with no overrun.
//     - shift_tick_out is combinational: (cnt>=clk_count_max) && !div_clk_out.
//       It therefore coincides with the edge where div_clk_out goes 0->1.
//   CS mux (registered, 1-cycle latency):
//     - cs_out_n[i] <= (i==cs_select_in) ? cs_sig_in : 1.
//     - A select value >= CS_SIZE drives all lines high.
//     - Never more than one line low.
//   PISO (updates only on a clk_in edge where shift_tick_out=1):
//     - load_in=1: reg<=data_in, bit count<=SIZE, empty_out<=0. Load has priority over shift.
//     - else if shift_en_in=1 and count>0: shift reg left, fill 0, count<=count-1.
//       empty_out<=1 when count reaches 0.
//     - else if shift_en_in=1 and count=0: hold; no underflow; serial_out stays 0.
//     - serial_out = reg[SIZE-1], MSB first. It changes in the cycle after the tick, i.e. after div_clk_out rises.
//     - The slave samples on the falling edge of div_clk_out.
//     - Without a tick, load_in and shift_en_in are ignored.
//   Reset mid-frame: immediate return to reset values; CS lines deassert asynchronously.
// CONFIGURATION
//   SPI_TX_LSB_FIRST_EN
//     - Defined: shift right, fill 0, serial_out=reg[0], LSB first.
//     - Undefined (default): MSB first as above.
//     - Count and empty_out behave identically in both modes.
// TESTING
//   1. max=0 -> div_clk_out toggles every clk_in; max=2 -> period 6 cycles, tick every 6 cycles.
//   2. Reset asserted -> cs_out_n=4'hF, serial_out=0, empty_out=1.
//      The values must hold even with select=2, sig=0 applied.
//   3. select=2, sig=0 -> cs_out_n=4'b1011 one clk later.
//      select=1 -> 4'b1101.
//   4. Load 40'h8000000001, then 40 ticks with shift_en=1:
//      serial_out=1, 0 x38, 1; empty_out=1 after 40th shift.
//   5. load_in and shift_en both high on a tick -> load wins, serial_out=data_in[SIZE-1].
//   6. Reset pulsed mid-frame after 10 shifts -> reg cleared, cs all 1.
//      After release, divider restarts at cnt=0 with div_clk_out=0.

Source files
------------

// File: rtl/spi_tx_datapath.sv
// spi_tx_datapath: transmit datapath of the SPI master.
// It contains a programmable bit-rate divider with a one-cycle shift tick, a
// registered active-low chip-select demux, and a PISO shift register that
// drives MOSI.
// Optional build macro SPI_TX_LSB_FIRST_EN: shift LSB first instead of MSB first.
module spi_tx_datapath #(
  parameter int SIZE     = 40,
  parameter int CS_SIZE  = 4,
  parameter int CLK_SIZE = 3
) (
  input  logic                                          clk_in,
  input  logic                                          reset_n_in,
  input  logic [CLK_SIZE-1:0]                           clk_count_max,
  output logic                                          div_clk_out,
  output logic                                          shift_tick_out,
  input  logic [((CS_SIZE > 1) ? $clog2(CS_SIZE) : 1)-1:0] cs_select_in,
  input  logic                                          cs_sig_in,
  output logic [CS_SIZE-1:0]                            cs_out_n,
  input  logic [SIZE-1:0]                               data_in,
  input  logic                                          load_in,
  input  logic                                          shift_en_in,
  output logic                                          serial_out,
  output logic                                          empty_out
);

  localparam int CNT_W = $clog2(SIZE + 1);

  logic [CLK_SIZE-1:0] div_cnt;
  logic                div_wrap;
  logic [CS_SIZE-1:0]  cs_next;
  logic [SIZE-1:0]     shift_reg;
  logic [CNT_W-1:0]    bit_cnt;

  // A >= compare lets a lowered terminal count take effect on the next edge.
  assign div_wrap       = (div_cnt >= clk_count_max);
  assign shift_tick_out = div_wrap && !div_clk_out;

  // Divider counter: wrap and toggle the divided clock at terminal count.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_cnt     <= '0;
      div_clk_out <= 1'b0;
    end else if (div_wrap) begin
      div_cnt     <= '0;
      div_clk_out <= ~div_clk_out;
    end else begin
      div_cnt     <= div_cnt + CLK_SIZE'(1);
    end
  end

  // Chip-select decode: only the addressed line follows cs_sig_in. An
  // out-of-range select matches no line, so every line stays high.
  always_comb begin
    cs_next = '1;
    for (int i = 0; i < CS_SIZE; i++) begin
      if (int'(cs_select_in) == i) cs_next[i] = cs_sig_in;
    end
  end

  // Chip-select register: one cycle of latency; reset deasserts all lines.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) cs_out_n <= '1;
    else             cs_out_n <= cs_next;
  end

  // PISO: acts only on tick edges. Load has priority over shift, and an empty
  // register holds instead of underflowing.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      empty_out <= 1'b1;
    end else if (shift_tick_out) begin
      if (load_in) begin
        shift_reg <= data_in;
        bit_cnt   <= CNT_W'(SIZE);
        empty_out <= 1'b0;
      end else if (shift_en_in && (bit_cnt != '0)) begin
`ifdef SPI_TX_LSB_FIRST_EN
        shift_reg <= {1'b0, shift_reg[SIZE-1:1]};
`else
        shift_reg <= {shift_reg[SIZE-2:0], 1'b0};
`endif
        bit_cnt   <= bit_cnt - CNT_W'(1);
        if (bit_cnt == CNT_W'(1)) empty_out <= 1'b1;
      end
    end
  end

`ifdef SPI_TX_LSB_FIRST_EN
  assign serial_out = shift_reg[0];
`else
  assign serial_out = shift_reg[SIZE-1];
`endif

endmodule

// File: tb/tb_spi_tx_datapath.sv
// tb_spi_tx_datapath: directed bench for spi_tx_datapath in the default (MSB-first) build.
module tb_spi_tx_datapath;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [2:0]  clk_count_max;
  logic        div_clk_out;
  logic        shift_tick_out;
  logic [1:0]  cs_select_in;
  logic        cs_sig_in;
  logic [3:0]  cs_out_n;
  logic [39:0] data_in;
  logic        load_in;
  logic        shift_en_in;
  logic        serial_out;
  logic        empty_out;

  int n_checks = 0;
  int n_pass   = 0;

  spi_tx_datapath #(.SIZE(40), .CS_SIZE(4), .CLK_SIZE(3)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .clk_count_max  (clk_count_max),
    .div_clk_out    (div_clk_out),
    .shift_tick_out (shift_tick_out),
    .cs_select_in   (cs_select_in),
    .cs_sig_in      (cs_sig_in),
    .cs_out_n       (cs_out_n),
    .data_in        (data_in),
    .load_in        (load_in),
    .shift_en_in    (shift_en_in),
    .serial_out     (serial_out),
    .empty_out      (empty_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Wait (bounded) for a tick at a negedge, present inputs across the tick edge.
  task automatic do_tick(input logic ld, input logic sh, input logic [39:0] d);
    int n = 0;
    while (shift_tick_out !== 1'b1 && n < 16) begin
      @(negedge clk_in);
      n++;
    end
    check("tick_seen", 64'(shift_tick_out), 64'd1);
    load_in     = ld;
    shift_en_in = sh;
    data_in     = d;
    @(posedge clk_in);
    @(negedge clk_in);
    load_in     = 1'b0;
    shift_en_in = 1'b0;
  endtask

  initial begin
    reset_n_in    = 1'b0;
    clk_count_max = 3'd2;
    cs_select_in  = 2'd2;
    cs_sig_in     = 1'b0;
    data_in       = '0;
    load_in       = 1'b0;
    shift_en_in   = 1'b0;

    // Reset holds outputs even with select=2, sig=0 applied
    repeat (3) @(negedge clk_in);
    check("rst_cs",     64'(cs_out_n),       64'hF);
    check("rst_serial", 64'(serial_out),     64'd0);
    check("rst_empty",  64'(empty_out),      64'd1);
    check("rst_div",    64'(div_clk_out),    64'd0);
    check("rst_tick",   64'(shift_tick_out), 64'd0);

    // max=2: period 6, tick after edges 2, 8, ...
    reset_n_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      check("div_m2",  64'(div_clk_out),    64'((k / 3) % 2));
      check("tick_m2", 64'(shift_tick_out), 64'((k % 6) == 2));
    end

    // CS demux
    check("cs_sel2", 64'(cs_out_n), 64'hB);
    cs_select_in = 2'd1;
    #1;
    check("cs_latency", 64'(cs_out_n), 64'hB);
    @(negedge clk_in);
    check("cs_sel1", 64'(cs_out_n), 64'hD);
    cs_select_in = 2'd3;
    @(negedge clk_in);
    check("cs_sel3", 64'(cs_out_n), 64'h7);
    cs_sig_in = 1'b1;
    @(negedge clk_in);
    check("cs_sig1", 64'(cs_out_n), 64'hF);

    // max=0: toggle every clk_in, tick while div low
    reset_n_in    = 1'b0;
    clk_count_max = 3'd0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      check("div_m0",  64'(div_clk_out),    64'(k % 2));
      check("tick_m0", 64'(shift_tick_out), 64'((k % 2) == 0));
    end

    // Frame 40'h8000000001: bits 1, 0 x38, 1
    do_tick(1'b1, 1'b0, 40'h80_0000_0001);
    check("ld_serial", 64'(serial_out), 64'd1);
    check("ld_empty",  64'(empty_out),  64'd0);
    for (int k = 1; k <= 40; k++) begin
      do_tick(1'b0, 1'b1, 40'h0);
      check("sh_serial", 64'(serial_out), 64'(k == 39));
      check("sh_empty",  64'(empty_out),  64'(k == 40));
    end
    do_tick(1'b0, 1'b1, 40'h0);
    check("under_serial", 64'(serial_out), 64'd0);
    check("under_empty",  64'(empty_out),  64'd1);

    // Load wins over shift
    do_tick(1'b1, 1'b1, 40'hA5_1234_5678);
    check("ldpri_serial", 64'(serial_out), 64'd1);
    check("ldpri_empty",  64'(empty_out),  64'd0);
    do_tick(1'b0, 1'b1, 40'h0);
    check("ldpri_shift", 64'(serial_out), 64'd0);

    // Load without tick is ignored
    check("notick_pre", 64'(shift_tick_out), 64'd0);
    load_in = 1'b1;
    data_in = 40'hFF_FFFF_FFFF;
    @(posedge clk_in);
    #1;
    load_in = 1'b0;
    check("notick_serial", 64'(serial_out), 64'd0);

    // Reset mid-frame after 10 shifts
    cs_select_in = 2'd0;
    cs_sig_in    = 1'b0;
    do_tick(1'b1, 1'b0, 40'hFF_FFFF_FFFF);
    for (int k = 1; k <= 10; k++) do_tick(1'b0, 1'b1, 40'h0);
    check("mid_serial", 64'(serial_out), 64'd1);
    check("mid_empty",  64'(empty_out),  64'd0);
    check("mid_cs",     64'(cs_out_n),   64'hE);
    reset_n_in = 1'b0;
    #1;
    check("async_cs",     64'(cs_out_n),    64'hF);
    check("async_serial", 64'(serial_out),  64'd0);
    check("async_empty",  64'(empty_out),   64'd1);
    check("async_div",    64'(div_clk_out), 64'd0);
    cs_sig_in     = 1'b1;
    clk_count_max = 3'd2;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      check("restart_div",  64'(div_clk_out),    64'(k == 3));
      check("restart_tick", 64'(shift_tick_out), 64'(k == 2));
    end
    check("restart_cs", 64'(cs_out_n), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
